// File: rtl/mips_defs.sv
// Shared MIPS encoding constants and the W-stage register/decode types.
// No logic; imported by the write-back stage and reusable by the hazard unit.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [4:0]  REG_RA = 5'd31;
    localparam logic [31:0] NOP    = 32'h0;

    typedef struct packed {
        logic       write;
        logic [4:0] a3;
        logic       link;
    } wb_dec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
        logic        valid;
    } wreg_t;

endpackage

// File: rtl/wb_decode.sv
// Destination decode: instruction -> {write, A3, link}; a3 is 0 when nothing is written.
// Purely combinational, no latency, no backpressure.
module wb_decode
    import mips_defs::*;
(
    input  logic [31:0] instr,
    output wb_dec_t     dec
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        dec = '0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO: dec = '0;
                default: begin
                    dec.write = 1'b1;
                    dec.a3    = rd;
                    dec.link  = (funct == FN_JALR);
                end
            endcase
        end else if ((op >= OP_ADDI && op <= OP_LUI) || op == OP_LB || op == OP_LH ||
                     op == OP_LW || op == OP_LBU || op == OP_LHU) begin
            dec.write = 1'b1;
            dec.a3    = rt;
        end else if (op == OP_JAL) begin
            dec.write = 1'b1;
            dec.a3    = REG_RA;
            dec.link  = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// M->W pipeline register, GRF write-port drive and retired-instruction counter.
// Latency 1 cycle; stall holds all state, flush loads a bubble and wins over stall.
module writeback_stage
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] PCM,
    input  logic [31:0] InstrM,
    input  logic [31:0] WDMW,
    output logic [31:0] PCW,
    output logic [31:0] InstrW,
    output logic        ValidW,
    output logic        GRFWE,
    output logic [4:0]  GRFA3,
    output logic [31:0] GRFWD,
    output logic [31:0] Retired
);

    wreg_t       w_q, w_d;
    logic [31:0] retired_q, retired_d;
    wb_dec_t     dec;

    always_comb begin
        w_d       = w_q;
        retired_d = retired_q;
        if (flush) begin
            w_d = '0;
        end else if (!stall) begin
            w_d.pc    = PCM;
            w_d.instr = InstrM;
            w_d.wd    = WDMW;
            w_d.valid = 1'b1;
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q       <= '0;
            retired_q <= '0;
        end else begin
            w_q       <= w_d;
            retired_q <= retired_d;
        end
    end

    wb_decode u_dec (
        .instr (w_q.instr),
        .dec   (dec)
    );

    assign PCW     = w_q.pc;
    assign InstrW  = w_q.instr;
    assign ValidW  = w_q.valid;
    assign Retired = retired_q;

    // Outputs depend only on registered state, so forwarding sees no input-to-output path.
    assign GRFWE = w_q.valid & dec.write & (dec.a3 != 5'd0);
    assign GRFA3 = (w_q.valid & dec.write) ? dec.a3 : 5'd0;
    assign GRFWD = dec.link ? (w_q.pc + 32'd8) : w_q.wd;

endmodule
